// File: rtl/apb3_bridge_nslv.sv
// apb3_bridge_nslv: APB3 bridge from one upstream completer port to N_SLV downstream requester ports.
//   clk, prst_n                          clock, async active-low reset
//   psel_s/penable_s/pwrite_s/paddr_s/pwdata_s   upstream request
//   prdata_s/pready_s/pslverr_s          upstream response (prdata_s registered)
//   psel_m (one-hot), penable_m/pwrite_m/paddr_m/pwdata_m   downstream request
//   prdata_m (flattened)/pready_m/pslverr_m                  downstream response
//   timeout_o                            one-cycle pulse when a transfer is aborted by timeout
module apb3_bridge_nslv #(
    parameter int N_SLV = 4,
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32,
    parameter logic [N_SLV*A_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [N_SLV*A_WIDTH-1:0] ADDR_MASK = '0,
    parameter int TIMEOUT = 256,
    parameter logic [D_WIDTH-1:0] ERR_RDATA = '0
) (
    input  logic                       clk,
    input  logic                       prst_n,
    input  logic                       psel_s,
    input  logic                       penable_s,
    input  logic                       pwrite_s,
    input  logic [A_WIDTH-1:0]         paddr_s,
    input  logic [D_WIDTH-1:0]         pwdata_s,
    output logic [D_WIDTH-1:0]         prdata_s,
    output logic                       pready_s,
    output logic                       pslverr_s,
    output logic [N_SLV-1:0]           psel_m,
    output logic                       penable_m,
    output logic                       pwrite_m,
    output logic [A_WIDTH-1:0]         paddr_m,
    output logic [D_WIDTH-1:0]         pwdata_m,
    input  logic [N_SLV*D_WIDTH-1:0]   prdata_m,
    input  logic [N_SLV-1:0]           pready_m,
    input  logic [N_SLV-1:0]           pslverr_m,
    output logic                       timeout_o
);
    localparam int IW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               r_state, w_next;
    logic [IW-1:0]        r_idx, w_idx;
    logic [CW-1:0]        r_cnt;
    logic                 r_err, r_to;
    logic [D_WIDTH-1:0]   r_prdata;
    logic                 w_start, w_hit, w_rdy, w_serr, w_to;
    logic [D_WIDTH-1:0]   w_rdata;

    assign w_start = psel_s & ~penable_s;
    assign w_rdy   = pready_m[r_idx];
    assign w_serr  = pslverr_m[r_idx];
    assign w_rdata = prdata_m[int'(r_idx)*D_WIDTH +: D_WIDTH];
    assign w_to    = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign prdata_s = r_prdata;

    // Scanning downward leaves the lowest matching index in w_idx.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((paddr_s & ADDR_MASK[i*A_WIDTH +: A_WIDTH]) ==
                (BASE_ADDR[i*A_WIDTH +: A_WIDTH] & ADDR_MASK[i*A_WIDTH +: A_WIDTH])) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge prst_n) begin
        if (!prst_n) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? (w_hit ? SETUP : RESP) : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (w_rdy | w_to) ? RESP : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        psel_m    = (r_state == SETUP || r_state == ACCESS) ? (N_SLV'(1) << r_idx) : '0;
        penable_m = (r_state == ACCESS);
        pready_s  = (r_state == RESP);
        pslverr_s = (r_state == RESP) & r_err;
        timeout_o = (r_state == RESP) & r_to;
    end

    // Shared downstream buses only update on a decode hit so they hold through misses.
    always_ff @(posedge clk or negedge prst_n) begin
        if (!prst_n) begin
            r_idx    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
            r_prdata <= '0;
            paddr_m  <= '0;
            pwdata_m <= '0;
            pwrite_m <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_err <= ~w_hit;
                    r_to  <= 1'b0;
                    if (w_hit) begin
                        r_idx    <= w_idx;
                        paddr_m  <= paddr_s;
                        pwdata_m <= pwdata_s;
                        pwrite_m <= pwrite_s;
                    end else begin
                        r_prdata <= ERR_RDATA;
                    end
                end
                SETUP: r_cnt <= '0;
                ACCESS: begin
                    if (w_rdy) begin
                        r_err    <= w_serr;
                        r_prdata <= w_serr ? ERR_RDATA : (pwrite_m ? '0 : w_rdata);
                    end else if (w_to) begin
                        r_err    <= 1'b1;
                        r_to     <= 1'b1;
                        r_prdata <= ERR_RDATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apb3_bridge_nslv.sv
// tb_apb3_bridge_nslv: scoreboard bench for apb3_bridge_nslv with four modelled downstream slaves.
module tb_apb3_bridge_nslv;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic          clk, prst_n;
    logic          psel_s, penable_s, pwrite_s;
    logic [31:0]   paddr_s, pwdata_s, prdata_s;
    logic          pready_s, pslverr_s;
    logic [3:0]    psel_m;
    logic          penable_m, pwrite_m;
    logic [31:0]   paddr_m, pwdata_m;
    logic [127:0]  prdata_m;
    logic [3:0]    pready_m, pslverr_m;
    logic          timeout_o;

    apb3_bridge_nslv #(
        .N_SLV(4), .A_WIDTH(32), .D_WIDTH(32),
        .BASE_ADDR({32'h3000, 32'h2000, 32'h1000, 32'h0000}),
        .ADDR_MASK({4{32'hF000}}),
        .TIMEOUT(6), .ERR_RDATA(ERR)
    ) dut (
        .clk(clk), .prst_n(prst_n),
        .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s),
        .paddr_s(paddr_s), .pwdata_s(pwdata_s),
        .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s),
        .psel_m(psel_m), .penable_m(penable_m), .pwrite_m(pwrite_m),
        .paddr_m(paddr_m), .pwdata_m(pwdata_m),
        .prdata_m(prdata_m), .pready_m(pready_m), .pslverr_m(pslverr_m),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;
    int waits[4];
    logic [31:0] srd[4];
    logic [3:0] serr;
    int acnt[4];
    int acc, to_cnt;
    logic [3:0] seen;
    logic [31:0] exp_wd, exp_ad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always_comb begin
        for (int i = 0; i < 4; i++) prdata_m[i*32 +: 32] = srd[i];
        pslverr_m = serr;
    end

    // Slave model: slave i asserts PREADY after waits[i] ACCESS cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (psel_m[i] && penable_m) begin
                pready_m[i] = (acnt[i] >= waits[i]);
                acnt[i]++;
            end else begin
                pready_m[i] = 1'b0;
                acnt[i] = 0;
            end
        end
    end

    // Bus monitor: shared buses must match the request while any select is active.
    always @(negedge clk) begin
        if (penable_m) acc++;
        if (timeout_o) to_cnt++;
        seen = seen | psel_m;
        if (psel_m != 0) begin
            chk("paddr_m", paddr_m, exp_ad);
            chk("pwdata_m", pwdata_m, exp_wd);
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int elat,
                        input logic [3:0] epsel);
        exp_t e;
        int k;
        sb.push_back('{rd: erd, err: eerr, lat: elat});
        @(negedge clk);
        psel_s = 1'b1; penable_s = 1'b0; pwrite_s = wr; paddr_s = addr; pwdata_s = wd;
        exp_wd = wd; exp_ad = addr; acc = 0; seen = '0;
        @(posedge clk);
        @(negedge clk);
        penable_s = 1'b1;
        k = 1;
        while (!pready_s && k < 50) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk("pready_s_seen", pready_s, 1'b1);
        chk("latency", k, e.lat);
        chk("prdata_s", prdata_s, e.rd);
        chk("pslverr_s", pslverr_s, e.err);
        @(posedge clk);
        #1 psel_s = 1'b0; penable_s = 1'b0;
        @(negedge clk);
        chk("pready_one_cycle", pready_s, 1'b0);
        chk("prdata_hold", prdata_s, e.rd);
        chk("psel_seen", seen, epsel);
    endtask

    initial begin
        prst_n = 1'b0; psel_s = 0; penable_s = 0; pwrite_s = 0; paddr_s = 0; pwdata_s = 0;
        pready_m = '0; serr = '0; acc = 0; to_cnt = 0; seen = '0; exp_wd = 0; exp_ad = 0;
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0; acnt[i] = 0; srd[i] = 32'h1111_0000 + 32'(i);
        end
        srd[2] = 32'hA5A5_0001;
        repeat (2) @(negedge clk);
        chk("rst_psel", psel_m, 4'h0);
        chk("rst_pready", pready_s, 1'b0);
        chk("rst_prdata", prdata_s, 32'h0);
        chk("rst_paddr", paddr_m, 32'h0);
        prst_n = 1'b1;

        xfer(1'b0, 32'h2004, 32'h0, 32'hA5A5_0001, 1'b0, 3, 4'b0100);
        waits[1] = 5;
        xfer(1'b1, 32'h1008, 32'h1234, 32'h0, 1'b0, 8, 4'b0010);
        chk("acc_wait5", acc, 6);
        xfer(1'b0, 32'h9000, 32'h0, ERR, 1'b1, 1, 4'b0000);
        chk("miss_paddr_hold", paddr_m, 32'h1008);
        waits[0] = 255;
        xfer(1'b0, 32'h0010, 32'h0, ERR, 1'b1, 8, 4'b0001);
        chk("acc_timeout", acc, 6);
        chk("timeout_pulses", to_cnt, 1);
        serr[3] = 1'b1;
        xfer(1'b0, 32'h3000, 32'h0, ERR, 1'b1, 3, 4'b1000);
        serr[3] = 1'b0;
        waits[0] = 0;
        xfer(1'b1, 32'h0004, 32'h55AA, 32'h0, 1'b0, 3, 4'b0001);

        waits[0] = 255;
        @(negedge clk);
        psel_s = 1'b1; penable_s = 1'b0; pwrite_s = 1'b1; paddr_s = 32'h0020; pwdata_s = 32'h77;
        exp_ad = 32'h0020; exp_wd = 32'h77;
        @(posedge clk);
        @(negedge clk);
        penable_s = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_penable", penable_m, 1'b1);
        prst_n = 1'b0;
        #1;
        chk("mid_rst_psel", psel_m, 4'h0);
        chk("mid_rst_penable", penable_m, 1'b0);
        chk("mid_rst_pwdata", pwdata_m, 32'h0);
        chk("mid_rst_prdata", prdata_s, 32'h0);
        chk("mid_rst_pready", pready_s, 1'b0);
        psel_s = 1'b0; penable_s = 1'b0;
        waits[0] = 0;
        @(negedge clk);
        prst_n = 1'b1;
        xfer(1'b0, 32'h2008, 32'h0, 32'hA5A5_0001, 1'b0, 3, 4'b0100);
        chk("timeout_total", to_cnt, 1);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
